stage_sequencer: RTL and testbench

Parametrised multicycle stage controller that drives the CPU's `stage` index (fetch, decode, execute, memory, writeback by default). It generalises the fixed auto/step stage stepping used by the top level.
- Configurable stage count.
- Synchronised, edge-detected manual step input.
- Stall input.
- PC breakpoint that drops auto mode into a halted single-step state.
- Retired-instruction counter.

It sits between the board inputs (`isAuto`, `nextStage`) and the CPU datapath control decode.

---
 rtl/stage_sequencer.sv | 91 +++++++++
 tb/tb_stage_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// ============================================================================
// stage_sequencer : multicycle CPU stage controller (auto/step/stall/breakpoint)
// Revision 1.0
// ============================================================================
`default_nettype none

module stage_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int STAGE_W    = 3,
  parameter int ADDR_W     = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              isAuto,
  input  logic              nextStage,
  input  logic              stallReq,
  input  logic [ADDR_W-1:0] pcAddr,
  input  logic              bpEn,
  input  logic [ADDR_W-1:0] bpAddr,
  output logic [STAGE_W-1:0] stage,
  output logic              advance,
  output logic              instDone,
  output logic              halted,
  output logic [CNT_W-1:0]  instCount
);

  localparam logic [STAGE_W-1:0] c_LAST = STAGE_W'(NUM_STAGES - 1);

  logic               r_auto_s1, r_auto_s2;
  logic               r_step_s1, r_step_s2, r_step_s3;
  logic [STAGE_W-1:0] r_stage;
  logic               r_advance, r_inst_done, r_halted;
  logic [CNT_W-1:0]   r_count;

  logic w_step, w_auto_run, w_go, w_wrap, w_bp_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_auto_s1 <= 1'b0;
      r_auto_s2 <= 1'b0;
      r_step_s1 <= 1'b0;
      r_step_s2 <= 1'b0;
      r_step_s3 <= 1'b0;
    end else begin
      r_auto_s1 <= isAuto;
      r_auto_s2 <= r_auto_s1;
      r_step_s1 <= nextStage;
      r_step_s2 <= r_step_s1;
      r_step_s3 <= r_step_s2;
    end
  end

  assign w_step     = r_step_s2 & ~r_step_s3;
  assign w_auto_run = r_auto_s2 & ~r_halted;
  assign w_go       = ~stallReq & (w_auto_run | w_step);
  // >= so that any out-of-range stage value still wraps on the next go
  assign w_wrap     = (r_stage >= c_LAST);
  assign w_bp_hit   = w_go & w_wrap & w_auto_run & bpEn & (pcAddr == bpAddr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage     <= '0;
      r_advance   <= 1'b0;
      r_inst_done <= 1'b0;
      r_halted    <= 1'b0;
      r_count     <= '0;
    end else begin
      r_advance   <= w_go;
      r_inst_done <= w_go & w_wrap;
      if (w_go) begin
        r_stage <= w_wrap ? '0 : r_stage + STAGE_W'(1);
        if (w_wrap && !(&r_count))
          r_count <= r_count + CNT_W'(1);
      end
      if (w_bp_hit)
        r_halted <= 1'b1;
      else if (~stallReq & (w_step | ~r_auto_s2))
        r_halted <= 1'b0;
    end
  end

  assign stage     = r_stage;
  assign advance   = r_advance;
  assign instDone  = r_inst_done;
  assign halted    = r_halted;
  assign instCount = r_count;

endmodule

`default_nettype wire

// File: tb/tb_stage_sequencer.sv
// ============================================================================
// tb_stage_sequencer : vector table, corner sequences and randomized model check
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_stage_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       isAuto, nextStage, stallReq, bpEn;
  logic [7:0] pcAddr, bpAddr;

  logic [2:0]  stage;
  logic        advance, instDone, halted;
  logic [15:0] instCount;
  logic [1:0]  stage2;
  logic        advance2, instDone2, halted2;
  logic [3:0]  instCount2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stage_sequencer #(.NUM_STAGES(5), .STAGE_W(3), .ADDR_W(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .isAuto(isAuto), .nextStage(nextStage), .stallReq(stallReq),
    .pcAddr(pcAddr), .bpEn(bpEn), .bpAddr(bpAddr),
    .stage(stage), .advance(advance), .instDone(instDone), .halted(halted),
    .instCount(instCount)
  );

  stage_sequencer #(.NUM_STAGES(3), .STAGE_W(2), .ADDR_W(8), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst(rst), .isAuto(isAuto), .nextStage(nextStage), .stallReq(stallReq),
    .pcAddr(pcAddr), .bpEn(bpEn), .bpAddr(bpAddr),
    .stage(stage2), .advance(advance2), .instDone(instDone2), .halted(halted2),
    .instCount(instCount2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: histories of raw input samples plus arithmetic stage/count rules.
  typedef struct {
    bit a0, a1;
    bit n0, n1, n2;
    int stg;
    bit adv, done, halt;
    int cnt;
  } m_t;

  m_t m5, m3;

  function automatic m_t mstep(m_t s, int n, int cmax);
    m_t r;
    bit auto_s, step, auto_run, go, wrap;
    r        = s;
    auto_s   = s.a1;
    step     = s.n1 && !s.n2;
    auto_run = auto_s && !s.halt;
    go       = !stallReq && (auto_run || step);
    wrap     = (s.stg == n - 1);
    r.adv    = go;
    r.done   = go && wrap;
    if (go) begin
      r.stg = (s.stg + 1) % n;
      if (wrap && s.cnt < cmax) r.cnt = s.cnt + 1;
    end
    if (go && wrap && auto_run && bpEn && pcAddr == bpAddr) r.halt = 1;
    else if (!stallReq && (step || !auto_s))                r.halt = 0;
    r.a1 = s.a0;  r.a0 = isAuto;
    r.n2 = s.n1;  r.n1 = s.n0;  r.n0 = nextStage;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m5 <= '{default: 0};
      m3 <= '{default: 0};
    end else begin
      m5 <= mstep(m5, 5, 65535);
      m3 <= mstep(m3, 3, 15);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_stage",  32'(stage),      32'(m5.stg));
      chk("m_adv",    32'(advance),    32'(m5.adv));
      chk("m_done",   32'(instDone),   32'(m5.done));
      chk("m_halt",   32'(halted),     32'(m5.halt));
      chk("m_cnt",    32'(instCount),  32'(m5.cnt));
      chk("m3_stage", 32'(stage2),     32'(m3.stg));
      chk("m3_adv",   32'(advance2),   32'(m3.adv));
      chk("m3_done",  32'(instDone2),  32'(m3.done));
      chk("m3_halt",  32'(halted2),    32'(m3.halt));
      chk("m3_cnt",   32'(instCount2), 32'(m3.cnt));
    end
  end

  typedef struct {
    bit au, ns, st, bpe;
    int es;
    bit ea, ed, eh;
    int ec;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit au, ns, st, bpe, input int es, input bit ea, ed, eh,
                     input int ec);
    tbl.push_back('{au, ns, st, bpe, es, ea, ed, eh, ec});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_stage"}, 32'(stage),     0);
    chk({tag, "_adv"},   32'(advance),   0);
    chk({tag, "_done"},  32'(instDone),  0);
    chk({tag, "_halt"},  32'(halted),    0);
    chk({tag, "_cnt"},   32'(instCount), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int n_adv, n_done, prev_cnt;
  bit seen;

  initial begin
    rst = 1'b1; isAuto = 0; nextStage = 0; stallReq = 0; bpEn = 0;
    pcAddr = 8'h10; bpAddr = 8'h10;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // auto run, breakpoint halt and step release, stall with dropped step
    add(1,0,0,0, 0,0,0,0,0); add(1,0,0,0, 0,0,0,0,0); add(1,0,0,0, 1,1,0,0,0);
    add(1,0,0,0, 2,1,0,0,0); add(1,0,0,0, 3,1,0,0,0); add(1,0,0,0, 4,1,0,0,0);
    add(1,0,0,0, 0,1,1,0,1); add(1,0,0,0, 1,1,0,0,1); add(1,0,0,0, 2,1,0,0,1);
    add(1,0,0,0, 3,1,0,0,1); add(1,0,0,0, 4,1,0,0,1); add(1,0,0,1, 0,1,1,1,2);
    add(1,0,0,0, 0,0,0,1,2); add(1,0,0,0, 0,0,0,1,2); add(1,1,0,0, 0,0,0,1,2);
    add(1,1,0,0, 0,0,0,1,2); add(1,0,0,0, 1,1,0,0,2); add(1,0,0,0, 2,1,0,0,2);
    add(1,0,0,0, 3,1,0,0,2); add(1,0,0,0, 4,1,0,0,2); add(1,0,0,0, 0,1,1,0,3);
    add(1,0,0,0, 1,1,0,0,3); add(1,0,0,0, 2,1,0,0,3); add(1,0,1,0, 2,0,0,0,3);
    add(1,1,1,0, 2,0,0,0,3); add(1,1,1,0, 2,0,0,0,3); add(1,0,1,0, 2,0,0,0,3);
    add(1,0,0,0, 3,1,0,0,3); add(1,0,0,0, 4,1,0,0,3); add(1,0,0,0, 0,1,1,0,4);

    foreach (tbl[i]) begin
      isAuto = tbl[i].au; nextStage = tbl[i].ns; stallReq = tbl[i].st; bpEn = tbl[i].bpe;
      @(negedge clk);
      chk($sformatf("vec%0d_stage", i), 32'(stage),     32'(tbl[i].es));
      chk($sformatf("vec%0d_adv", i),   32'(advance),   32'(tbl[i].ea));
      chk($sformatf("vec%0d_done", i),  32'(instDone),  32'(tbl[i].ed));
      chk($sformatf("vec%0d_halt", i),  32'(halted),    32'(tbl[i].eh));
      chk($sformatf("vec%0d_cnt", i),   32'(instCount), 32'(tbl[i].ec));
    end

    // halt again, then asynchronous reset while halted
    bpEn = 1; pcAddr = 8'h22; bpAddr = 8'h22;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = halted;
    end
    chk("bp_halt_seen", 32'(seen), 1);
    bpEn = 0;
    repeat (3) @(negedge clk);
    chk("halt_hold_stage", 32'(stage), 0);
    chk("halt_hold_flag",  32'(halted), 1);
    #2 rst = 1'b1;
    #1 check_zero("arst_halted");
    #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("restart%0d_stage", k), 32'(stage), (k < 2) ? 0 : k - 1);
    end
    #2 rst = 1'b1;
    #1 check_zero("arst_stage3");
    #1 rst = 1'b0;
    @(negedge clk);
    chk("restart_from0", 32'(stage), 0);

    // manual mode: held step gives one pulse, then two short pulses
    isAuto = 0;
    do_reset();
    n_adv = 0; n_done = 0;
    repeat (3) @(negedge clk);
    nextStage = 1;
    for (int k = 0; k < 80; k++) begin
      if (k == 50 || k == 59 || k == 68) nextStage = 0;
      if (k == 56 || k == 65)            nextStage = 1;
      @(negedge clk);
      n_adv  += int'(advance);
      n_done += int'(instDone);
    end
    chk("step_adv_count",  32'(n_adv), 3);
    chk("step_done_count", 32'(n_done), 0);
    chk("step_stage",      32'(stage), 3);

    // 3-stage instance: counter saturation
    isAuto = 1;
    do_reset();
    prev_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (stage2 > 2'd2 || int'(instCount2) < prev_cnt)
        chk("sat_monotonic", 32'(instCount2), 32'(prev_cnt));
      prev_cnt = int'(instCount2);
    end
    chk("sat_cnt3",   32'(instCount2), 15);
    chk("sat_halted", 32'(halted2), 0);

    // randomized traffic against the model
    bpAddr = 8'h2;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) isAuto = ~isAuto;
      if ($urandom_range(0, 3) == 0)  nextStage = ~nextStage;
      stallReq = ($urandom_range(0, 5) == 0);
      bpEn     = $urandom_range(0, 1) == 1;
      pcAddr   = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
